uart_rx: RTL and testbench

- Serial receiver for the frame format our UART transmitter produces: 1 start bit (0), 8 data bits LSB first, 1 odd-parity bit, 1 stop bit (1).
- Oversamples the asynchronous line with the system clock and samples each bit at mid-bit.
- Delivers each received byte with a one-cycle strobe plus parity and framing error flags.
- Sits between the board RS-232 RX pin and user logic; its parallel output mirrors the transmitter's parallel input.

---
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : serial receiver, 1 start / 8 data (LSB first) / odd parity / 1 stop
//
// The line is oversampled with clk and each bit is taken at mid-bit. Every
// received frame is delivered with a one-cycle strobe, even when its parity
// or stop bit is wrong (the matching error flag is set).
//
// Optional build macro: UART_RX_MAJORITY_EN
//   defined   -> each bit value is the 2-of-3 majority of the synchronized
//                line over the reference cycle and the two cycles before it
//                (needs SYS_CLK/BAUD - 1 >= 4)
//   undefined -> single sample at the reference cycle
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   in_data    in   asynchronous serial line, idle high
//   out_data   out  [7:0] last received byte, held until next strobe
//   out_en     out  one-cycle strobe when out_data/flags update
//   parity_err out  odd parity of last frame wrong
//   frame_err  out  stop bit of last frame sampled low
//   busy       out  receiver is inside a frame (state != IDLE)
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int BAUD    = 9600,
   parameter int SYS_CLK = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_data,
   output logic [7:0] out_data,
   output logic       out_en,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam int MAX   = SYS_CLK / BAUD - 1;
   localparam int HALF  = MAX / 2;
   localparam int WIDTH = $clog2(MAX + 1);

   localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] HALF_C = WIDTH'(HALF);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] cnt, cnt_nx;
   logic [2:0]       bit_idx, bit_idx_nx;
   logic [7:0]       shift, shift_nx;
   logic             par_s, par_s_nx;
   logic [7:0]       out_data_nx;
   logic             out_en_nx, parity_err_nx, frame_err_nx;

   // Synchronizer and edge history. All clear to 0 on reset, so a line that
   // is low through reset cannot fake a start edge: it must be seen high first.
   logic sync1, sync2, prev;
   logic sample;
   logic fall;

`ifdef UART_RX_MAJORITY_EN
   logic prev2;

   always_ff @(posedge clk) begin
      if (rst) prev2 <= 1'b0;
      else     prev2 <= prev;
   end

   // sync2/prev/prev2 are the line at ref, ref-1 and ref-2
   assign sample = (sync2 & prev) | (sync2 & prev2) | (prev & prev2);
`else
   assign sample = sync2;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= in_data;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign fall = prev & ~sync2;
   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         par_s      <= 1'b0;
         out_data   <= 8'h00;
         out_en     <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         bit_idx    <= bit_idx_nx;
         shift      <= shift_nx;
         par_s      <= par_s_nx;
         out_data   <= out_data_nx;
         out_en     <= out_en_nx;
         parity_err <= parity_err_nx;
         frame_err  <= frame_err_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt + WIDTH'(1);
      bit_idx_nx    = bit_idx;
      shift_nx      = shift;
      par_s_nx      = par_s;
      out_data_nx   = out_data;
      out_en_nx     = 1'b0;
      parity_err_nx = parity_err;
      frame_err_nx  = frame_err;

      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (fall) state_nx = START;
         end
         START: begin
            // Half a bit in: a line back high means the edge was a glitch.
            if (cnt == HALF_C) begin
               cnt_nx = '0;
               if (!sample) begin
                  state_nx   = DATA;
                  bit_idx_nx = '0;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt == MAX_C) begin
               cnt_nx     = '0;
               shift_nx   = {sample, shift[7:1]};
               bit_idx_nx = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_nx = PARITY;
            end
         end
         PARITY: begin
            if (cnt == MAX_C) begin
               cnt_nx   = '0;
               par_s_nx = sample;
               state_nx = STOP;
            end
         end
         STOP: begin
            // Leave at mid-stop-bit so an immediately following start edge
            // is caught from IDLE.
            if (cnt == MAX_C) begin
               cnt_nx        = '0;
               out_en_nx     = 1'b1;
               out_data_nx   = shift;
               parity_err_nx = ~(^{shift, par_s});
               frame_err_nx  = ~sample;
               state_nx      = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : scoreboard bench for uart_rx (SYS_CLK=1 MHz, BAUD=100 kHz,
// so one bit = 10 clocks). Frames are driven on the falling clock edge; the
// expected byte/flags are queued at stimulus time and compared on each strobe.
// ---------------------------------------------------------------------------
module tb_uart_rx;

   localparam int BIT = 10;   // clocks per bit
   localparam int LAT = 108;  // line fall -> out_en: 3 + HALF + 10*BIT + 1

   logic       clk = 1'b0;
   logic       rst;
   logic       in_data;
   logic [7:0] out_data;
   logic       out_en, parity_err, frame_err, busy;

   uart_rx #(.BAUD(100_000), .SYS_CLK(1_000_000)) dut (
      .clk(clk), .rst(rst), .in_data(in_data),
      .out_data(out_data), .out_en(out_en),
      .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_strobe = 0;
   bit   lat_arm  = 1'b0;
   int   t0       = 0;
   logic prev_en  = 1'b0;

   // strobe monitor
   always @(negedge clk) begin
      if (out_en) begin
         n_strobe++;
         check("out_en_consec", int'(prev_en), 0);
         check("busy_at_strobe", int'(busy), 0);
         if (sb.size() == 0) begin
            check("spurious_strobe", int'(out_en), 0);
         end else begin
            mon_e = sb.pop_front();
            check("out_data", int'(out_data), int'(mon_e.d));
            check("parity_err", int'(parity_err), int'(mon_e.pe));
            check("frame_err", int'(frame_err), int'(mon_e.fe));
            if (lat_arm) begin
               check("latency", cyc - t0, LAT);
               lat_arm = 1'b0;
            end
         end
      end
      prev_en = out_en;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic send(input logic [7:0] d, input logic p, input logic s);
      exp_t e;
      e.d  = d;
      e.pe = ($countones({d, p}) % 2) == 0;
      e.fe = !s;
      sb.push_back(e);
      t0 = cyc;
      in_data = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         in_data = d[i];
         repeat (BIT) @(negedge clk);
      end
      in_data = p;
      repeat (BIT) @(negedge clk);
      in_data = s;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_data = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 400; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      check("drain_timeout", sb.size(), 0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_out_data"}, int'(out_data), 0);
      check({tag, "_out_en"}, int'(out_en), 0);
      check({tag, "_parity_err"}, int'(parity_err), 0);
      check({tag, "_frame_err"}, int'(frame_err), 0);
      check({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      int nbusy;
      logic [7:0] d77;

      rst = 1'b1;
      in_data = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      idle(20);

      // 1: single clean frame, with latency check
      lat_arm = 1'b1;
      send(8'hA5, 1'b1, 1'b1);
      idle(20);
      drain();
      check("latency_armed", int'(lat_arm), 0);

      // 2: back-to-back frames, trailing idle bit before the third
      send(8'h00, 1'b1, 1'b1);
      send(8'hFF, 1'b1, 1'b1);
      idle(BIT);
      send(8'h3C, 1'b1, 1'b1);
      idle(20);
      drain();

      // 3: wrong parity
      send(8'h01, 1'b1, 1'b1);
      idle(20);
      drain();

      // 4: two-cycle low glitch: busy for START cnt 0..HALF only, no strobe
      nbusy = 0;
      in_data = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i == 1) in_data = 1'b1;
         if (busy) nbusy++;
      end
      check("glitch_busy_cycles", nbusy, 5);

      // 5: framing error, line held low, then a clean frame
      send(8'h55, 1'b1, 1'b0);
      in_data = 1'b0;
      repeat (40) @(negedge clk);
      check("low_line_busy", int'(busy), 0);
      idle(20);
      send(8'h12, 1'b1, 1'b1);
      idle(20);
      drain();

      // 6: reset during data bit 4 of 0x77, then 0x9C
      d77 = 8'h77;
      in_data = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         in_data = d77[i];
         repeat (BIT) @(negedge clk);
      end
      in_data = d77[4];
      repeat (5) @(negedge clk);
      check("midframe_busy", int'(busy), 1);
      rst = 1'b1;
      @(negedge clk);
      check_zero("midreset");
      rst = 1'b0;
      idle(30);
      send(8'h9C, 1'b1, 1'b1);
      idle(20);
      drain();

      repeat (50) @(negedge clk);
      check("strobe_count", n_strobe, 8);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
